mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit for the NPC execute stage. It takes the M-extension operations that the single-cycle integer datapath does not implement, and computes them over multiple cycles with a radix-2 shift-add or restoring-subtract loop. It receives operands from decode through a valid/ready handshake and returns a 32-bit result to writeback through a second valid/ready handshake. It holds at most one operation at a time.

---
 rtl/mdu_iter_if.sv | 24 ++
 rtl/mdu_iter.sv | 145 ++++++++++++++
 tb/tb_mdu_iter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Operand/result handshake bundle between decode, the multiply/divide unit and writeback.
interface mdu_iter_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output in_valid, op, a, b, kill, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, op, a, b, kill, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide on magnitudes.
// Holds one operation; special divide cases complete without iterating.
module mdu_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic      clk,
   input  logic      rst,
   mdu_iter_if.slave bus
);
   localparam int unsigned W  = XLEN;
   localparam int unsigned W2 = 2 * XLEN;
   localparam int unsigned CW = 6;
   localparam logic [CW-1:0] LAST    = CW'(XLEN - 1);
   localparam logic [W-1:0]  INT_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state;
   logic [2:0]     op_q;
   logic           neg_q;
   logic [CW-1:0]  cnt;
   logic [W2-1:0]  acc;
   logic [W-1:0]   opb;
   logic           in_ready_q;
   logic           out_valid_q;
   logic [W-1:0]   result_q;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;

   // Operand signedness, magnitudes and result sign at accept
   logic         is_div, sgn_a, sgn_b, a_neg, b_neg, neg_in;
   logic [W-1:0] a_mag, b_mag;
   logic         div_zero, div_ovf, special;
   logic [W-1:0] spec_res;

   assign is_div   = bus.op[2];
   assign sgn_a    = is_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
   assign sgn_b    = is_div ? ~bus.op[0] : ~bus.op[1];
   assign a_neg    = sgn_a & bus.a[W-1];
   assign b_neg    = sgn_b & bus.b[W-1];
   assign a_mag    = a_neg ? W'(~bus.a + W'(1)) : bus.a;
   assign b_mag    = b_neg ? W'(~bus.b + W'(1)) : bus.b;
   assign neg_in   = (is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
   assign div_zero = is_div && (bus.b == '0);
   assign div_ovf  = is_div && !bus.op[0] && (bus.a == INT_MIN) && (bus.b == '1);
   assign special  = div_zero || div_ovf;
   assign spec_res = div_zero ? (bus.op[1] ? bus.a : '1)
                              : (bus.op[1] ? '0 : INT_MIN);

   // One radix-2 step; the divide trial uses the bit shifted out of the top
   logic [W:0]    add_sum;
   logic [W:0]    sub_diff;
   logic [W2-1:0] acc_nx;

   always_comb begin
      add_sum  = {1'b0, acc[W2-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
      sub_diff = acc[W2-1:W-1] - {1'b0, opb};
      acc_nx   = {add_sum, acc[W-1:1]};
      if (op_q[2]) begin
         if (sub_diff[W])
            acc_nx = {acc[W2-2:0], 1'b0};
         else
            acc_nx = {sub_diff[W-1:0], acc[W-2:0], 1'b1};
      end
   end

   // Final sign fix-up and half/quotient/remainder selection
   logic [W2-1:0] prod;
   logic [W-1:0]  sel;
   logic [W-1:0]  quo;
   logic [W-1:0]  fin_res;

   always_comb begin
      prod = neg_q ? W2'(~acc_nx + W2'(1)) : acc_nx;
      sel  = op_q[1] ? acc_nx[W2-1:W] : acc_nx[W-1:0];
      quo  = neg_q ? W'(~sel + W'(1)) : sel;
      if (op_q[2])
         fin_res = quo;
      else if (op_q[1:0] == 2'b00)
         fin_res = prod[W-1:0];
      else
         fin_res = prod[W2-1:W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         cnt         <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         acc         <= '0;
         opb         <= '0;
      end else if (bus.kill) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op_q       <= bus.op;
                  neg_q      <= neg_in;
                  cnt        <= '0;
                  acc        <= {{W{1'b0}}, a_mag};
                  opb        <= b_mag;
                  in_ready_q <= 1'b0;
                  if (special) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= spec_res;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               acc <= acc_nx;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= fin_res;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic results, latency, backpressure, kill and async reset.
module tb_mdu_iter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned total = 0;
   int unsigned bad   = 0;

   mdu_iter_if #(.XLEN(32)) bus ();
   mdu_iter #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op, wait for the result, check latency/value, then hand it off
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat_exp);
      int lat;
      bus.op = op;
      bus.a  = a;
      bus.b  = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
      chk({tag, "_res"}, bus.result, exp);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_drop"}, {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
   endtask

   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.kill      = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      chk("reset_hs", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
      chk("reset_res", bus.result, 32'h0);
      rst = 1'b0;
      tick();

      run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
      run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        33);
      run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         33);
      run_op("divu0",  3'b101, 32'd55,        32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem0",   3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 1);
      run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

      // Backpressure: result and handshake hold while writeback stalls
      bus.op = 3'b101; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      seen = 0;
      while (!bus.out_valid && seen < 100) begin
         tick();
         seen++;
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", {30'b0, bus.in_ready, bus.out_valid}, 32'h1);
         chk("bp_res", bus.result, 32'd14);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp_release", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);

      // kill with in_valid in IDLE must not accept
      bus.op = 3'b000; bus.a = 32'd5; bus.b = 32'd6;
      bus.in_valid = 1'b1; bus.kill = 1'b1;
      tick();
      bus.in_valid = 1'b0; bus.kill = 1'b0;
      chk("kill_noacc", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);

      // kill at iteration 10
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (10) tick();
      chk("kill_busy", {30'b0, bus.in_ready, bus.out_valid}, 32'h0);
      bus.kill = 1'b1;
      tick();
      bus.kill = 1'b0;
      chk("kill_idle", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
      seen = 0;
      repeat (40) begin
         tick();
         if (bus.out_valid) seen++;
      end
      chk("kill_quiet", 32'(seen), 32'd0);
      run_op("divu_post_kill", 3'b101, 32'd9, 32'd3, 32'd3, 33);

      // Asynchronous reset mid-BUSY, observed between clock edges
      bus.op = 3'b000; bus.a = 32'd7; bus.b = 32'hFFFF_FFFD; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_async_hs", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
      chk("rst_async_res", bus.result, 32'h0);
      #1 rst = 1'b0;
      run_op("mulhu_post_rst", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
